// File: rtl/debounce_moore.sv
// Debouncer: 2-flop synchronizer feeding a 4-state Moore FSM that accepts a new
// level only after STABLE_CYCLES consecutive identical synchronized samples.
module debounce_moore #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic       out,
   output logic [1:0] dbg_state
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_LOW       = 2'b00,
      S_WAIT_HIGH = 2'b01,
      S_HIGH      = 2'b10,
      S_WAIT_LOW  = 2'b11
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            sync1_q;
   logic            sync2_q;

   // cnt_q holds the number of consecutive new-level samples seen so far in a WAIT state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= S_LOW;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         case (state_q)
            S_LOW: begin
               if (sync2_q) begin
                  state_q <= S_WAIT_HIGH;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            S_WAIT_HIGH: begin
               if (!sync2_q) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!sync2_q) begin
                  state_q <= S_WAIT_LOW;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            S_WAIT_LOW: begin
               if (sync2_q) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Output is a pure decode of the state register: high in S_HIGH and S_WAIT_LOW.
   assign out       = (state_q == S_HIGH) || (state_q == S_WAIT_LOW);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_debounce_moore.sv
// Self-checking bench for debounce_moore: directed latency/bounce/reset scenarios
// plus randomized levels checked against a run-length reference model.
module tb_debounce_moore;

   localparam int STABLE = 4;

   logic       clk;
   logic       rst_r;
   logic       in_r;
   logic       out;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   debounce_moore #(.STABLE_CYCLES(STABLE)) dut (
      .clk       (clk),
      .rst       (rst_r),
      .in        (in_r),
      .out       (out),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: input seen two edges late; the output level flips once
   // the delayed input has disagreed with it for STABLE consecutive edges.
   logic m_d1, m_d2, m_out;
   int   m_run;

   always @(posedge clk or posedge rst_r) begin
      if (rst_r) begin
         m_d1  <= 1'b0;
         m_d2  <= 1'b0;
         m_out <= 1'b0;
         m_run <= 0;
      end else begin
         m_d1 <= in_r;
         m_d2 <= m_d1;
         if (m_d2 != m_out) begin
            if (m_run + 1 >= STABLE) begin
               m_out <= ~m_out;
               m_run <= 0;
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
      end
   end

   function automatic logic [1:0] model_dbg();
      return {m_out, (m_run != 0)};
   endfunction

   task automatic test_reset();
      in_r  = 1'b0;
      rst_r = 1'b0;
      #1 rst_r = 1'b1;
      #1;
      checks++;
      if (out !== 1'b0 || dbg_state !== 2'b00) begin
         failures++;
         $display("FAIL reset_pre_edge out=%b dbg=%b required out=0 dbg=00", out, dbg_state);
      end
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out !== 1'b0 || dbg_state !== 2'b00) begin
            failures++;
            $display("FAIL reset_edge%0d out=%b dbg=%b required out=0 dbg=00", k, out, dbg_state);
         end
      end
      rst_r = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("test_reset done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_rise();
      logic [1:0] exp_dbg;
      in_r = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         exp_dbg = (k < 3) ? 2'b00 : (k < STABLE + 2) ? 2'b01 : 2'b10;
         checks++;
         if (dbg_state !== exp_dbg || out !== exp_dbg[1]) begin
            failures++;
            $display("FAIL rise_e%0d out=%b dbg=%b required out=%b dbg=%b",
                     k, out, dbg_state, exp_dbg[1], exp_dbg);
         end
      end
      $display("test_rise done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_fall();
      logic [1:0] exp_dbg;
      in_r = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         exp_dbg = (k < 3) ? 2'b10 : (k < STABLE + 2) ? 2'b11 : 2'b00;
         checks++;
         if (dbg_state !== exp_dbg || out !== exp_dbg[1]) begin
            failures++;
            $display("FAIL fall_e%0d out=%b dbg=%b required out=%b dbg=%b",
                     k, out, dbg_state, exp_dbg[1], exp_dbg);
         end
      end
      $display("test_fall done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_bounce();
      logic pattern [3] = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         in_r = pattern[k];
         @(posedge clk); #1;
         checks++;
         if (out !== 1'b0) begin
            failures++;
            $display("FAIL bounce_b%0d out=%b required 0", k, out);
         end
      end
      in_r = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out !== (k >= STABLE + 2)) begin
            failures++;
            $display("FAIL bounce_e%0d out=%b required %b", k, out, (k >= STABLE + 2));
         end
      end
      in_r = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (out !== 1'b0 || dbg_state !== 2'b00) begin
         failures++;
         $display("FAIL bounce_settle out=%b dbg=%b required out=0 dbg=00", out, dbg_state);
      end
      $display("test_bounce done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_glitch();
      logic [1:0] exp_dbg;
      in_r = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         in_r = 1'b0;
         exp_dbg = (k == 3) ? 2'b01 : 2'b00;
         checks++;
         if (dbg_state !== exp_dbg || out !== 1'b0) begin
            failures++;
            $display("FAIL glitch_e%0d out=%b dbg=%b required out=0 dbg=%b", k, out, dbg_state, exp_dbg);
         end
      end
      $display("test_glitch done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_dbg;
      in_r = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         exp_dbg = (k < 3) ? 2'b00 : 2'b01;
         checks++;
         if (dbg_state !== exp_dbg) begin
            failures++;
            $display("FAIL rstmid_pre_e%0d dbg=%b required %b", k, dbg_state, exp_dbg);
         end
      end
      #2 rst_r = 1'b1;
      #1;
      checks++;
      if (out !== 1'b0 || dbg_state !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_async out=%b dbg=%b required out=0 dbg=00", out, dbg_state);
      end
      // The edge below would have completed the wait; reset must win.
      @(posedge clk); #1;
      checks++;
      if (out !== 1'b0 || dbg_state !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_dominate out=%b dbg=%b required out=0 dbg=00", out, dbg_state);
      end
      #3 rst_r = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_dbg = (k < 3) ? 2'b00 : (k < STABLE + 2) ? 2'b01 : 2'b10;
         checks++;
         if (dbg_state !== exp_dbg || out !== exp_dbg[1]) begin
            failures++;
            $display("FAIL rstmid_post_e%0d out=%b dbg=%b required out=%b dbg=%b",
                     k, out, dbg_state, exp_dbg[1], exp_dbg);
         end
      end
      $display("test_reset_mid done out=%b dbg=%b", out, dbg_state);
   endtask

   task automatic test_random();
      logic prev_out;
      int   since;
      prev_out = out;
      since    = STABLE;
      for (int seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 9) == 0) begin
            #2 rst_r = 1'b1;
            #1;
            checks++;
            if (out !== 1'b0 || dbg_state !== 2'b00) begin
               failures++;
               $display("FAIL rand_rst seg=%0d out=%b dbg=%b required out=0 dbg=00", seg, out, dbg_state);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2 rst_r = 1'b0;
            prev_out = 1'b0;
            since    = 0;
         end
         in_r = 1'($urandom_range(0, 1));
         for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
            @(posedge clk); #1;
            checks++;
            if (out !== m_out || dbg_state !== model_dbg()) begin
               failures++;
               $display("FAIL rand_model seg=%0d out=%b dbg=%b required out=%b dbg=%b",
                        seg, out, dbg_state, m_out, model_dbg());
            end
            if (out !== prev_out) begin
               checks++;
               if (since < STABLE) begin
                  failures++;
                  $display("FAIL rand_spacing seg=%0d gap=%0d required >=%0d", seg, since, STABLE);
               end
               since = 1;
            end else begin
               since++;
            end
            prev_out = out;
         end
         $display("rand seg=%0d in=%b out=%b dbg=%b", seg, in_r, out, dbg_state);
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_fall();
      test_bounce();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
